abc_stim_driver: RTL



---
 rtl/abc_pkg.sv | 47 ++++
 rtl/abc_step_rom.sv | 21 ++
 rtl/abc_stim_driver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/abc_pkg.sv
// Shared definitions for the A/B/C latch self-test driver.
//   - state_e      : driver FSM states
//   - vec_t        : one sequence step {a, b, c, hold}
//   - SeqTable     : the fixed 12-step stimulus sequence
//   - IdleVec      : value driven while not running (A=B=C=1)
//   - clamp_hold() : hold counts below 2 are stretched to 2
package abc_pkg;

  localparam int unsigned SeqLen    = 12;
  localparam int unsigned HoldWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  typedef struct packed {
    logic                 a;
    logic                 b;
    logic                 c;
    logic [HoldWidth-1:0] hold;
  } vec_t;

  localparam vec_t IdleVec = '{a: 1'b1, b: 1'b1, c: 1'b1, hold: HoldWidth'(2)};

  localparam vec_t SeqTable [SeqLen] = '{
    '{a: 1'b1, b: 1'b1, c: 1'b1, hold: 8'd10},
    '{a: 1'b0, b: 1'b1, c: 1'b1, hold: 8'd10},
    '{a: 1'b1, b: 1'b1, c: 1'b1, hold: 8'd5},
    '{a: 1'b1, b: 1'b0, c: 1'b1, hold: 8'd5},
    '{a: 1'b1, b: 1'b0, c: 1'b0, hold: 8'd5},
    '{a: 1'b1, b: 1'b1, c: 1'b0, hold: 8'd5},
    '{a: 1'b1, b: 1'b1, c: 1'b1, hold: 8'd5},
    '{a: 1'b1, b: 1'b0, c: 1'b1, hold: 8'd10},
    '{a: 1'b1, b: 1'b1, c: 1'b1, hold: 8'd10},
    '{a: 1'b0, b: 1'b1, c: 1'b1, hold: 8'd10},
    '{a: 1'b1, b: 1'b1, c: 1'b1, hold: 8'd5},
    '{a: 1'b1, b: 1'b1, c: 1'b0, hold: 8'd10}
  };

  // A step must last at least two cycles so the model has settled before the compare.
  function automatic logic [HoldWidth-1:0] clamp_hold(input logic [HoldWidth-1:0] h);
    return (h < HoldWidth'(2)) ? HoldWidth'(2) : h;
  endfunction

endpackage

// File: rtl/abc_step_rom.sv
// Combinational sequence-table lookup.
//   idx : step index (0..DEPTH-1)
//   vec : {a, b, c, hold} for that step; out-of-range indices return the idle
//         vector (1,1,1) with hold 2
module abc_step_rom
  import abc_pkg::*;
#(
  parameter int unsigned DEPTH = SeqLen
) (
  input  logic [3:0] idx,
  output vec_t       vec
);

  always_comb begin
    vec = IdleVec;
    if (32'(idx) < DEPTH && 32'(idx) < SeqLen) begin
      vec = SeqTable[idx];
    end
  end

endmodule

// File: rtl/abc_stim_driver.sv
// Stimulus driver and checker for the three-input set/hold latch
// (Y = ~B | ~C | (A & Y)). A START pulse plays the step table, holding each
// vector for max(hold,2) cycles, while a reference model tracks the expected Y.
// The returned Y is compared on the last cycle of every step.
//   CLK     : clock, rising edge
//   RST_N   : synchronous active-low reset
//   START   : run request pulse, honoured only when not running
//   Y_IN    : Y from the latch under test
//   A/B/C   : driven latch inputs (1,1,1 when idle)
//   BUSY    : sequence running
//   DONE    : run finished, held until next START or reset
//   STEP    : index of the step being driven
//   EXP_Y   : reference-model Y
//   ERR_CNT : saturating count of step-end mismatches
module abc_stim_driver
  import abc_pkg::*;
#(
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned ERR_W  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             Y_IN,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       STEP,
  output logic             EXP_Y,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam logic [3:0]       LastStep = 4'(DEPTH - 1);
  localparam logic [ERR_W-1:0] ErrMax   = '1;

  state_e            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              a_q, a_d, b_q, b_d, c_q, c_d;
  logic              exp_q, exp_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic [3:0]        rom_idx;
  vec_t              rom_vec;
  logic [HOLD_W-1:0] reload;
  logic              last_cycle;

  // While running, look ahead to the next step; otherwise look up step 0 for a start.
  assign rom_idx = (state_q == StRun) ? step_q + 4'd1 : 4'd0;

  abc_step_rom #(
    .DEPTH (DEPTH)
  ) u_rom (
    .idx (rom_idx),
    .vec (rom_vec)
  );

  // Counter runs hold-1 .. 0, so zero marks the step's final cycle.
  assign reload     = HOLD_W'(clamp_hold(rom_vec.hold) - HoldWidth'(1));
  assign last_cycle = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    exp_d   = exp_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle, StFin: begin
        if (START) begin
          state_d = StRun;
          step_d  = 4'd0;
          cnt_d   = reload;
          a_d     = rom_vec.a;
          b_d     = rom_vec.b;
          c_d     = rom_vec.c;
          exp_d   = 1'b1;
          err_d   = '0;
        end
      end
      StRun: begin
        // Model follows the vector currently on the pins.
        exp_d = ~b_q | ~c_q | (a_q & exp_q);
        cnt_d = cnt_q - HOLD_W'(1);
        if (last_cycle) begin
          if ((Y_IN != exp_q) && (err_q != ErrMax)) begin
            err_d = err_q + ERR_W'(1);
          end
          if (step_q == LastStep) begin
            state_d = StFin;
            step_d  = 4'd0;
            cnt_d   = '0;
            a_d     = IdleVec.a;
            b_d     = IdleVec.b;
            c_d     = IdleVec.c;
          end else begin
            step_d = step_q + 4'd1;
            cnt_d  = reload;
            a_d    = rom_vec.a;
            b_d    = rom_vec.b;
            c_d    = rom_vec.c;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      step_q  <= 4'd0;
      cnt_q   <= '0;
      a_q     <= 1'b1;
      b_q     <= 1'b1;
      c_q     <= 1'b1;
      exp_q   <= 1'b1;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign C       = c_q;
  assign BUSY    = (state_q == StRun);
  assign DONE    = (state_q == StFin);
  assign STEP    = step_q;
  assign EXP_Y   = exp_q;
  assign ERR_CNT = err_q;

endmodule
